// File: rtl/ichip_pkg.sv
// Shared types for the ichip accumulator CPU: default widths, opcode set and state encoding.
// Optional shifter is selected by ICHIP_SHIFT_EN (see ichip_cpu).
package ichip_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_STA = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_NOT = 4'd8,
        OP_LDI = 4'd9,
        OP_JMP = 4'd10,
        OP_JZ  = 4'd11,
        OP_JN  = 4'd12,
        OP_SHL = 4'd13,
        OP_SHR = 4'd14,
        OP_HLT = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_e;

endpackage

// File: rtl/ichip_mem.sv
// Unified program/data memory: combinational read, synchronous write, contents survive reset.
module ichip_mem
    import ichip_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/ichip_cpu.sv
// Two-cycle (FETCH/EXEC) accumulator CPU around a single shared memory.
// Define ICHIP_SHIFT_EN to build SHL/SHR; otherwise those opcodes execute as NOP.
module ichip_cpu
    import ichip_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);

    logic [ADDR_W-1:0] counter;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ir;
    state_e            s;
    logic              halted_q;

    opcode_e           op;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    assign op = opcode_e'(ir[DATA_W-1 -: 4]);
    assign a  = ir[ADDR_W-1:0];

    // One port serves both phases: FETCH reads at counter, EXEC reads/writes the operand.
    assign mem_addr = (s == EXEC) ? a : counter;
    assign mem_we   = rst_n && (s == EXEC) && (op == OP_STA);

    ichip_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (acc),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= '0;
            acc      <= '0;
            ir       <= '0;
            s        <= FETCH;
            halted_q <= 1'b0;
        end else begin
            case (s)
                FETCH: begin
                    ir      <= mem_rdata;
                    counter <= counter + 1'b1;
                    s       <= EXEC;
                end
                EXEC: begin
                    s <= FETCH;
                    case (op)
                        OP_LDA: acc <= mem_rdata;
                        OP_ADD: acc <= acc + mem_rdata;
                        OP_SUB: acc <= acc - mem_rdata;
                        OP_AND: acc <= acc & mem_rdata;
                        OP_OR:  acc <= acc | mem_rdata;
                        OP_XOR: acc <= acc ^ mem_rdata;
                        OP_NOT: acc <= ~acc;
                        OP_LDI: acc <= {{(DATA_W-12){1'b0}}, ir[11:0]};
                        OP_JMP: counter <= a;
                        OP_JZ:  if (acc == '0) counter <= a;
                        OP_JN:  if (acc[DATA_W-1]) counter <= a;
`ifdef ICHIP_SHIFT_EN
                        OP_SHL: acc <= acc << 1;
                        OP_SHR: acc <= acc >> 1;
`endif
                        OP_HLT: begin
                            s        <= HALT;
                            halted_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_ichip_cpu.sv
// Directed and randomized checks of ichip_cpu against an instruction-level interpreter.
module tb_ichip_cpu;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic halted;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] mm [1024];
    logic [15:0] m_acc;
    logic [15:0] m_ir;
    logic [9:0]  m_pc;
    logic        m_halt;

    ichip_cpu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Executes one whole instruction on the ISA-level model.
    function automatic void m_step();
        logic [9:0] ad;
        if (m_halt) return;
        m_ir = mm[m_pc];
        m_pc = m_pc + 10'd1;
        ad   = m_ir[9:0];
        case (m_ir[15:12])
            4'd1:  m_acc = mm[ad];
            4'd2:  mm[ad] = m_acc;
            4'd3:  m_acc = m_acc + mm[ad];
            4'd4:  m_acc = m_acc - mm[ad];
            4'd5:  m_acc = m_acc & mm[ad];
            4'd6:  m_acc = m_acc | mm[ad];
            4'd7:  m_acc = m_acc ^ mm[ad];
            4'd8:  m_acc = ~m_acc;
            4'd9:  m_acc = {4'h0, m_ir[11:0]};
            4'd10: m_pc = ad;
            4'd11: if (m_acc == 16'h0) m_pc = ad;
            4'd12: if (m_acc[15]) m_pc = ad;
`ifdef ICHIP_SHIFT_EN
            4'd13: m_acc = m_acc << 1;
            4'd14: m_acc = m_acc >> 1;
`endif
            4'd15: m_halt = 1'b1;
            default: ;
        endcase
    endfunction

    task automatic clear_mm();
        for (int i = 0; i < 1024; i++) mm[i] = 16'h0000;
    endtask

    task automatic reset_and_load(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, " rst counter"}, 16'(dut.counter), 16'h0000);
        chk({tag, " rst acc"}, dut.acc, 16'h0000);
        chk({tag, " rst s"}, 16'(dut.s), 16'h0001);
        chk({tag, " rst halted"}, 16'(halted), 16'h0000);
        for (int i = 0; i < 1024; i++) dut.mem.mem[i] <= mm[i];
        m_acc = 16'h0; m_pc = 10'h0; m_ir = 16'h0; m_halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step_chk(input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_step();
        chk({tag, " counter"}, 16'(dut.counter), 16'(m_pc));
        chk({tag, " acc"}, dut.acc, m_acc);
        chk({tag, " ir"}, dut.ir, m_ir);
        chk({tag, " halted"}, 16'(halted), 16'(m_halt));
        chk({tag, " s"}, 16'(dut.s), m_halt ? 16'h0000 : 16'h0001);
    endtask

    task automatic mem_chk(input string tag);
        int diffs = 0;
        for (int i = 0; i < 1024; i++)
            if (dut.mem.mem[i] !== mm[i]) diffs++;
        chk({tag, " mem diffs"}, 16'(diffs), 16'h0000);
    endtask

    initial begin
        // Add/store/halt program with exact halt timing.
        clear_mm();
        mm[0] = 16'h1191; mm[1] = 16'h3192; mm[2] = 16'h2193; mm[3] = 16'hF000;
        mm[401] = 16'h0005; mm[402] = 16'h0007;
        reset_and_load("add");
        for (int i = 0; i < 3; i++) step_chk("add");
        @(posedge clk); @(negedge clk);
        chk("add edge7 halted", 16'(halted), 16'h0000);
        @(posedge clk); @(negedge clk);
        chk("add edge8 halted", 16'(halted), 16'h0001);
        chk("add edge8 s", 16'(dut.s), 16'h0000);
        chk("add mem403", dut.mem.mem[403], 16'h000C);
        m_step();
        mem_chk("add");
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("halt hold counter", 16'(dut.counter), 16'(m_pc));
        chk("halt hold acc", dut.acc, 16'h000C);
        chk("halt hold ir", dut.ir, 16'hF000);
        mem_chk("halt hold");

        // SUB underflow then JN taken.
        clear_mm();
        mm[0] = 16'h9000; mm[1] = 16'h4100; mm[2] = 16'hC020;
        mm[16'h100] = 16'h0001; mm[16'h020] = 16'hF000;
        reset_and_load("jn");
        step_chk("jn");
        step_chk("jn");
        chk("sub wrap acc", dut.acc, 16'hFFFF);
        step_chk("jn");
        chk("jn taken counter", 16'(dut.counter), 16'h0020);
        step_chk("jn");

        // JZ not taken, then taken after LDI 0.
        clear_mm();
        mm[0] = 16'h9001; mm[1] = 16'hB050; mm[2] = 16'h9000; mm[3] = 16'hB050;
        mm[16'h050] = 16'hF000;
        reset_and_load("jz");
        step_chk("jz");
        step_chk("jz");
        chk("jz not taken counter", 16'(dut.counter), 16'h0002);
        step_chk("jz");
        step_chk("jz");
        chk("jz taken counter", 16'(dut.counter), 16'h0050);

        // JMP to the last word, NOP there, counter wraps to 0.
        clear_mm();
        mm[0] = 16'hA3FF;
        reset_and_load("wrap");
        step_chk("wrap");
        step_chk("wrap");
        chk("wrap counter", 16'(dut.counter), 16'h0000);
        @(posedge clk); @(negedge clk);
        chk("wrap fetch ir", dut.ir, 16'hA3FF);
        chk("wrap fetch counter", 16'(dut.counter), 16'h0001);
        chk("wrap fetch s", 16'(dut.s), 16'h0002);

        // Reset during EXEC of a store suppresses the write.
        clear_mm();
        mm[0] = 16'h9055; mm[1] = 16'h21A0; mm[16'h1A0] = 16'h1234;
        reset_and_load("rsta");
        step_chk("rsta");
        @(posedge clk); @(negedge clk);
        chk("rsta in exec s", 16'(dut.s), 16'h0002);
        rst_n = 1'b0;
        #1;
        chk("rsta counter", 16'(dut.counter), 16'h0000);
        chk("rsta s", 16'(dut.s), 16'h0001);
        chk("rsta acc", dut.acc, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rsta mem", dut.mem.mem[16'h1A0], 16'h1234);
        m_acc = 16'h0; m_pc = 10'h0; m_ir = 16'h0; m_halt = 1'b0;
        step_chk("rsta rerun");
        step_chk("rsta rerun");
        chk("rsta rerun mem", dut.mem.mem[16'h1A0], 16'h0055);
        mem_chk("rsta rerun");

        // Shifts (or NOP when the shifter is not built).
        clear_mm();
        mm[0] = 16'h9801; mm[1] = 16'hD000; mm[2] = 16'hE000; mm[3] = 16'hF000;
        reset_and_load("shift");
        step_chk("shift");
        step_chk("shift");
`ifdef ICHIP_SHIFT_EN
        chk("shl acc", dut.acc, 16'h1002);
`else
        chk("shl acc", dut.acc, 16'h0801);
`endif
        step_chk("shift");
        chk("shr acc", dut.acc, 16'h0801);
        step_chk("shift");

        // Random memory images run as programs.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 1024; i++) begin
                mm[i] = 16'($urandom);
                if (mm[i][15:12] == 4'hF && $urandom_range(3) != 0) mm[i][15:12] = 4'h9;
            end
            reset_and_load($sformatf("rnd%0d", r));
            for (int k = 0; k < 40; k++) step_chk($sformatf("rnd%0d.%0d", r, k));
            mem_chk($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
